// File: rtl/level_meter_pkg.sv
// Shared types and helpers for the level meter slice.
package level_meter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    typedef enum logic {
        BAR = 1'b0,
        DOT = 1'b1
    } mode_t;

    // Smallest r such that 2**r >= value; exact log2 for powers of two.
    function automatic int log2_ceil(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/level_meter_chan.sv
// Per-channel combinational step: magnitude with saturation, envelope
// attack/decay, lit LED count and clip counter update.
module level_meter_chan
    import level_meter_pkg::*;
#(
    parameter int SAMPLE_W    = 16,
    parameter int NUM_LEDS    = 8,
    parameter int DECAY_SHIFT = 4,
    parameter int CLIP_HOLD   = 8,
    localparam int ENV_W      = SAMPLE_W - 1,
    localparam int LIT_W      = log2_ceil(NUM_LEDS) + 1,
    localparam int CLIP_W     = (log2_ceil(CLIP_HOLD + 1) < 1) ? 1 : log2_ceil(CLIP_HOLD + 1)
) (
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic        [ENV_W-1:0]    env,
    input  logic        [CLIP_W-1:0]   clip_cnt,
    output logic        [ENV_W-1:0]    env_next,
    output logic        [LIT_W-1:0]    lit_next,
    output logic        [CLIP_W-1:0]   clip_cnt_next
);

    // Each LED covers 2**SHIFT_S magnitude codes.
    localparam int SHIFT_S = SAMPLE_W - 1 - log2_ceil(NUM_LEDS);
    localparam logic [ENV_W-1:0] A_MAX = {ENV_W{1'b1}};

    logic [ENV_W-1:0] mag;
    logic [ENV_W-1:0] decay;
    logic [ENV_W-1:0] decayed;

    // Magnitude; the most negative code has no positive twin and saturates.
    always_comb begin
        mag = sample[ENV_W-1:0];
        if (sample[SAMPLE_W-1]) begin
            if (sample[ENV_W-1:0] == '0) begin
                mag = A_MAX;
            end else begin
                mag = ~sample[ENV_W-1:0] + ENV_W'(1);
            end
        end
    end

    // Instant attack, exponential decay with a minimum step of one code.
    always_comb begin
        decay = env >> DECAY_SHIFT;
        if (decay == '0 && env != '0) begin
            decay = ENV_W'(1);
        end
        decayed  = env - decay;
        env_next = (mag > decayed) ? mag : decayed;
    end

    // LED count and clip hold counter.
    always_comb begin
        if (env_next == '0) begin
            lit_next = '0;
        end else begin
            lit_next = LIT_W'((env_next - ENV_W'(1)) >> SHIFT_S) + LIT_W'(1);
        end
        if (mag == A_MAX) begin
            clip_cnt_next = CLIP_W'(CLIP_HOLD);
        end else if (clip_cnt != '0) begin
            clip_cnt_next = clip_cnt - CLIP_W'(1);
        end else begin
            clip_cnt_next = '0;
        end
    end

endmodule

// File: rtl/level_meter.sv
// Multi-channel LED level meter with a time-multiplexed channel datapath.
// Optional peak-hold marker: define LEVEL_METER_PEAK_HOLD_EN.
//
// state  | meaning
// IDLE   | ready high, waiting for a frame strobe
// CALC   | one channel per cycle through the shared datapath
// COMMIT | register LED pattern and clip flags, then back to IDLE
module level_meter
    import level_meter_pkg::*;
#(
    parameter int SAMPLE_W     = 16,
    parameter int NUM_CH       = 2,
    parameter int NUM_LEDS     = 8,
    parameter int DECAY_SHIFT  = 4,
    parameter int HOLD_SAMPLES = 4,
    parameter int CLIP_HOLD    = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CH*SAMPLE_W-1:0]   samples_in,
    input  logic                         sample_valid,
    input  logic                         mode,
    output logic                         ready,
    output logic [NUM_CH*NUM_LEDS-1:0]   lights,
    output logic [NUM_CH-1:0]            clip
);

    localparam int ENV_W  = SAMPLE_W - 1;
    localparam int LIT_W  = log2_ceil(NUM_LEDS) + 1;
    localparam int CLIP_W = (log2_ceil(CLIP_HOLD + 1) < 1) ? 1 : log2_ceil(CLIP_HOLD + 1);
    localparam int CH_W   = (NUM_CH > 1) ? log2_ceil(NUM_CH) : 1;

    state_t                       state_q, state_d;
    logic [CH_W-1:0]              ch_q, ch_d;
    logic [NUM_CH*SAMPLE_W-1:0]   frame_q;
    logic [ENV_W-1:0]             env_q      [NUM_CH];
    logic [CLIP_W-1:0]            clip_cnt_q [NUM_CH];
    logic [LIT_W-1:0]             lit_q      [NUM_CH];

    logic signed [SAMPLE_W-1:0]   cur_sample;
    logic [ENV_W-1:0]             env_next;
    logic [LIT_W-1:0]             lit_next;
    logic [CLIP_W-1:0]            clip_next;
    logic [NUM_CH*NUM_LEDS-1:0]   pattern;
    logic                         led_on;
    mode_t                        mode_sel;

    assign mode_sel   = mode_t'(mode);
    assign ready      = (state_q == IDLE);
    assign cur_sample = frame_q[ch_q*SAMPLE_W +: SAMPLE_W];

    level_meter_chan #(
        .SAMPLE_W    (SAMPLE_W),
        .NUM_LEDS    (NUM_LEDS),
        .DECAY_SHIFT (DECAY_SHIFT),
        .CLIP_HOLD   (CLIP_HOLD)
    ) u_chan (
        .sample        (cur_sample),
        .env           (env_q[ch_q]),
        .clip_cnt      (clip_cnt_q[ch_q]),
        .env_next      (env_next),
        .lit_next      (lit_next),
        .clip_cnt_next (clip_next)
    );

    // FSM state and channel index register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    // Next-state logic; strobes outside IDLE are simply not looked at.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    state_d = CALC;
                    ch_d    = '0;
                end
            end
            CALC: begin
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    state_d = COMMIT;
                    ch_d    = '0;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            COMMIT: state_d = IDLE;
            default: begin
                state_d = IDLE;
                ch_d    = '0;
            end
        endcase
    end

    // Capture the frame on acceptance so later input changes cannot leak in.
    always_ff @(posedge clock) begin
        if (!reset) begin
            frame_q <= '0;
        end else if (state_q == IDLE && sample_valid) begin
            frame_q <= samples_in;
        end
    end

`ifdef LEVEL_METER_PEAK_HOLD_EN
    localparam int HOLD_W = (log2_ceil(HOLD_SAMPLES + 1) < 1) ? 1 : log2_ceil(HOLD_SAMPLES + 1);

    logic [LIT_W-1:0]  peak_q [NUM_CH];
    logic [HOLD_W-1:0] hold_q [NUM_CH];
    logic [LIT_W-1:0]  peak_next;
    logic [HOLD_W-1:0] hold_next;

    // Peak marker: jump up immediately, otherwise count down the hold then step.
    // n below peak implies peak is non-zero, so the final branch cannot underflow.
    always_comb begin
        peak_next = peak_q[ch_q];
        hold_next = hold_q[ch_q];
        if (lit_next >= peak_q[ch_q]) begin
            peak_next = lit_next;
            hold_next = HOLD_W'(HOLD_SAMPLES);
        end else if (hold_q[ch_q] != '0) begin
            hold_next = hold_q[ch_q] - HOLD_W'(1);
        end else begin
            peak_next = peak_q[ch_q] - LIT_W'(1);
            hold_next = HOLD_W'(HOLD_SAMPLES);
        end
    end

    // Peak and hold registers, written for the channel in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                peak_q[c] <= '0;
                hold_q[c] <= '0;
            end
        end else if (state_q == CALC) begin
            peak_q[ch_q] <= peak_next;
            hold_q[ch_q] <= hold_next;
        end
    end
`endif

    // Per-channel envelope, clip counter and lit count, written during CALC.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                env_q[c]      <= '0;
                clip_cnt_q[c] <= '0;
                lit_q[c]      <= '0;
            end
        end else if (state_q == CALC) begin
            env_q[ch_q]      <= env_next;
            clip_cnt_q[ch_q] <= clip_next;
            lit_q[ch_q]      <= lit_next;
        end
    end

    // Bar/dot encoding of the stored counts, with the peak marker ORed in.
    always_comb begin
        pattern = '0;
        led_on  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (mode_sel == BAR) begin
                    led_on = (LIT_W'(i) < lit_q[c]);
                end else begin
                    led_on = (LIT_W'(i + 1) == lit_q[c]);
                end
`ifdef LEVEL_METER_PEAK_HOLD_EN
                led_on = led_on | (LIT_W'(i + 1) == peak_q[c]);
`endif
                pattern[c*NUM_LEDS + i] = led_on;
            end
        end
    end

    // Display registers, refreshed once per frame.
    always_ff @(posedge clock) begin
        if (!reset) begin
            lights <= '0;
            clip   <= '0;
        end else if (state_q == COMMIT) begin
            lights <= pattern;
            for (int c = 0; c < NUM_CH; c++) begin
                clip[c] <= (clip_cnt_q[c] != '0);
            end
        end
    end

endmodule
